// File: rtl/mm_pkg.sv
// Shared definitions for the load/store-multiple sequencer: class decode,
// architectural register numbers, FSM state encoding and a popcount helper.
package mm_pkg;

  // Class decode: (instr16 & mask) == {opcode, zeros}
  localparam logic [15:0] MASK_LDMSTM  = 16'hF800;
  localparam logic [15:0] MASK_PUSHPOP = 16'hFE00;
  localparam logic [4:0]  OP_STM       = 5'b11000;
  localparam logic [4:0]  OP_LDM       = 5'b11001;
  localparam logic [6:0]  OP_PUSH      = 7'b1011010;
  localparam logic [6:0]  OP_POP       = 7'b1011110;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // Widest possible transfer list: eight low registers plus LR/PC.
  localparam int unsigned MAX_LIST_BITS = 9;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StFin  = 2'd2
  } mm_state_e;

  function automatic logic [3:0] popcount9(input logic [MAX_LIST_BITS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < int'(MAX_LIST_BITS); i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mm_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest 1 and an any-set flag.
module mm_prio_enc #(
  parameter int unsigned WIDTH = 9,
  localparam int unsigned IdxW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IdxW-1:0]  o_idx,
  output logic             o_valid
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = |i_vec;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/mm_xfer_seq.sv
// Multi-cycle LDM/STM/PUSH/POP sequencer: walks the register list, issues one
// word transfer per accepted cycle and reports the base writeback at the end.
module mm_xfer_seq
  import mm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LIST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is32,
  input  logic [15:0]       instr16,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  input  logic              abort,
  output logic              busy,
  output logic              stall_fetch,
  output logic              xfer_valid,
  output logic              xfer_write,
  output logic [ADDR_W-1:0] xfer_addr,
  output logic [3:0]        xfer_reg,
  output logic              wb_valid,
  output logic [3:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_data,
  output logic              done
);

  localparam int unsigned ListBits = LIST_W + 1;
  localparam int unsigned CntW     = $clog2(LIST_W + 2);
  localparam int unsigned IdxW     = $clog2(ListBits);

  mm_state_e r_state, w_state_nxt;

  logic [LIST_W:0]     r_list;
  logic [CntW-1:0]     r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [3:0]          r_extra_reg;
  logic                r_wb_en;
  logic [3:0]          r_wb_reg;
  logic [ADDR_W-1:0]   r_wb_data;

  logic                w_is_stm, w_is_ldm, w_is_push, w_is_pop, w_is_pp, w_class;
  logic                w_accept;
  logic [LIST_W:0]     w_list;
  logic [MAX_LIST_BITS-1:0] w_list9;
  logic [3:0]          w_n;
  logic [ADDR_W-1:0]   w_n4, w_base_dn, w_base_up;
  logic [2:0]          w_rn;
  logic                w_rn_in_list;
  logic                w_wb_en;
  logic [IdxW-1:0]     w_idx;
  logic                w_idx_valid;
  logic [LIST_W:0]     w_clr_mask;
  logic [3:0]          w_reg;
  logic                w_xfer_valid, w_fire, w_done, w_wb_valid;

  // Instruction class decode.
  assign w_is_stm  = (instr16 & MASK_LDMSTM)  == {OP_STM, 11'b0};
  assign w_is_ldm  = (instr16 & MASK_LDMSTM)  == {OP_LDM, 11'b0};
  assign w_is_push = (instr16 & MASK_PUSHPOP) == {OP_PUSH, 9'b0};
  assign w_is_pop  = (instr16 & MASK_PUSHPOP) == {OP_POP, 9'b0};
  assign w_is_pp   = w_is_push | w_is_pop;
  assign w_class   = w_is_stm | w_is_ldm | w_is_pp;

  // Abort in the same cycle as start also blocks acceptance.
  assign w_accept = start & ~is32 & (r_state == StIdle) & w_class & ~abort;

  // Top list bit stands for LR (PUSH) or PC (POP); never set for LDM/STM.
  assign w_list = {w_is_pp & instr16[8], instr16[LIST_W-1:0]};
  assign w_rn   = instr16[10:8];

  // Pack the list into the fixed-width popcount input.
  always_comb begin
    w_list9                 = '0;
    w_list9[LIST_W-1:0]     = instr16[LIST_W-1:0];
    w_list9[MAX_LIST_BITS-1] = w_is_pp & instr16[8];
  end

  assign w_n       = popcount9(w_list9);
  assign w_n4      = ADDR_W'({w_n, 2'b00});
  assign w_base_dn = base_addr - w_n4;
  assign w_base_up = base_addr + w_n4;

  // LDM suppresses writeback when the base register is itself loaded.
  always_comb begin
    w_rn_in_list = 1'b0;
    for (int i = 0; i < int'(LIST_W); i++) begin
      if ((w_rn == 3'(i)) && instr16[i]) begin
        w_rn_in_list = 1'b1;
      end
    end
  end

  // Empty list completes without writeback.
  assign w_wb_en = (w_n != 4'd0) &
                   (w_is_stm | w_is_pp | (w_is_ldm & ~w_rn_in_list));

  mm_prio_enc #(
    .WIDTH(ListBits)
  ) u_prio_enc (
    .i_vec  (r_list),
    .o_idx  (w_idx),
    .o_valid(w_idx_valid)
  );

  assign w_clr_mask = {{LIST_W{1'b0}}, 1'b1} << w_idx;
  assign w_reg      = (w_idx == IdxW'(LIST_W)) ? r_extra_reg : 4'(w_idx);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state strobes; abort beats mem_ready.
  always_comb begin
    w_state_nxt  = r_state;
    w_xfer_valid = 1'b0;
    w_fire       = 1'b0;
    w_done       = 1'b0;
    w_wb_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = (w_n == 4'd0) ? StFin : StXfer;
        end
      end
      StXfer: begin
        w_xfer_valid = 1'b1;
        if (abort) begin
          w_state_nxt = StIdle;
        end else if (mem_ready) begin
          w_fire = 1'b1;
          if (r_cnt == CntW'(1)) begin
            w_state_nxt = StFin;
          end
        end
      end
      StFin: begin
        w_state_nxt = StIdle;
        if (!abort) begin
          w_done     = 1'b1;
          w_wb_valid = r_wb_en;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Latch the sequence on accept; retire one list bit per accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_list      <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_extra_reg <= '0;
      r_wb_en     <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_data   <= '0;
    end else if (w_accept) begin
      r_list      <= w_list;
      r_cnt       <= CntW'(w_n);
      r_addr      <= w_is_push ? w_base_dn : base_addr;
      r_write     <= w_is_stm | w_is_push;
      r_extra_reg <= w_is_push ? REG_LR : REG_PC;
      r_wb_en     <= w_wb_en;
      r_wb_reg    <= w_is_pp ? REG_SP : {1'b0, w_rn};
      r_wb_data   <= w_is_push ? w_base_dn : w_base_up;
    end else if (w_fire) begin
      r_list <= r_list & ~w_clr_mask;
      r_cnt  <= r_cnt - CntW'(1);
      r_addr <= r_addr + ADDR_W'(4);
    end
  end

  // Outputs are gated by state so idle and reset present all zeros.
  assign busy        = (r_state != StIdle);
  assign stall_fetch = busy;
  assign xfer_valid  = w_xfer_valid;
  assign xfer_write  = w_xfer_valid & r_write;
  assign xfer_addr   = w_xfer_valid ? r_addr : '0;
  assign xfer_reg    = (w_xfer_valid & w_idx_valid) ? w_reg : '0;
  assign wb_valid    = w_wb_valid;
  assign wb_reg      = w_wb_valid ? r_wb_reg : '0;
  assign wb_data     = w_wb_valid ? r_wb_data : '0;
  assign done        = w_done;

endmodule

// File: tb/tb_mm_xfer_seq.sv
// Directed bench for mm_xfer_seq: inputs change and outputs are sampled on
// the falling edge, away from the rising active edge.
module tb_mm_xfer_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is32;
  logic [15:0] instr16;
  logic [31:0] base_addr;
  logic        mem_ready;
  logic        abort;
  logic        busy;
  logic        stall_fetch;
  logic        xfer_valid;
  logic        xfer_write;
  logic [31:0] xfer_addr;
  logic [3:0]  xfer_reg;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        done;

  int n_checks;
  int n_fail;

  mm_xfer_seq #(
    .ADDR_W(32),
    .LIST_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is32       (is32),
    .instr16    (instr16),
    .base_addr  (base_addr),
    .mem_ready  (mem_ready),
    .abort      (abort),
    .busy       (busy),
    .stall_fetch(stall_fetch),
    .xfer_valid (xfer_valid),
    .xfer_write (xfer_write),
    .xfer_addr  (xfer_addr),
    .xfer_reg   (xfer_reg),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a start for one cycle; returns at the next falling edge.
  task automatic issue(input logic [15:0] ins, input logic [31:0] base);
    start     = 1'b1;
    instr16   = ins;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic xfer_chk(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [3:0] rg);
    check_eq({tag, ".valid"}, 64'(xfer_valid), 64'd1);
    check_eq({tag, ".write"}, 64'(xfer_write), 64'(wr));
    check_eq({tag, ".addr"}, 64'(xfer_addr), 64'(addr));
    check_eq({tag, ".reg"}, 64'(xfer_reg), 64'(rg));
    check_eq({tag, ".stall"}, 64'(stall_fetch), 64'd1);
    @(negedge clk);
  endtask

  task automatic fin_chk(input string tag, input logic wbv, input logic [3:0] rg,
                         input logic [31:0] data);
    check_eq({tag, ".done"}, 64'(done), 64'd1);
    check_eq({tag, ".xvalid"}, 64'(xfer_valid), 64'd0);
    check_eq({tag, ".wbv"}, 64'(wb_valid), 64'(wbv));
    if (wbv) begin
      check_eq({tag, ".wbreg"}, 64'(wb_reg), 64'(rg));
      check_eq({tag, ".wbdata"}, 64'(wb_data), 64'(data));
    end
    @(negedge clk);
    check_eq({tag, ".idle"}, 64'(busy), 64'd0);
    check_eq({tag, ".done_off"}, 64'(done), 64'd0);
  endtask

  task automatic all_zero_chk(input string tag);
    check_eq({tag, ".busy"}, 64'(busy), 64'd0);
    check_eq({tag, ".stall"}, 64'(stall_fetch), 64'd0);
    check_eq({tag, ".xvalid"}, 64'(xfer_valid), 64'd0);
    check_eq({tag, ".xwrite"}, 64'(xfer_write), 64'd0);
    check_eq({tag, ".xaddr"}, 64'(xfer_addr), 64'd0);
    check_eq({tag, ".xreg"}, 64'(xfer_reg), 64'd0);
    check_eq({tag, ".wbv"}, 64'(wb_valid), 64'd0);
    check_eq({tag, ".wbreg"}, 64'(wb_reg), 64'd0);
    check_eq({tag, ".wbdata"}, 64'(wb_data), 64'd0);
    check_eq({tag, ".done"}, 64'(done), 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is32      = 1'b0;
    instr16   = '0;
    base_addr = '0;
    mem_ready = 1'b1;
    abort     = 1'b0;
    #1;
    all_zero_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // PUSH {r0,r2,lr}: N=3, start 0x20000100-12
    issue(16'hB505, 32'h2000_0100);
    xfer_chk("push0", 1'b1, 32'h2000_00F4, 4'd0);
    xfer_chk("push1", 1'b1, 32'h2000_00F8, 4'd2);
    xfer_chk("push2", 1'b1, 32'h2000_00FC, 4'd14);
    fin_chk("push", 1'b1, 4'd13, 32'h2000_00F4);

    // LDM r1!,{r0,r3}: base not in list -> writeback r1
    issue(16'hC909, 32'h0000_1000);
    xfer_chk("ldm0", 1'b0, 32'h0000_1000, 4'd0);
    xfer_chk("ldm1", 1'b0, 32'h0000_1004, 4'd3);
    fin_chk("ldm", 1'b1, 4'd1, 32'h0000_1008);

    // LDM r0,{r0,r1}: base in list -> no writeback
    issue(16'hC803, 32'h0000_2000);
    xfer_chk("ldmb0", 1'b0, 32'h0000_2000, 4'd0);
    xfer_chk("ldmb1", 1'b0, 32'h0000_2004, 4'd1);
    fin_chk("ldmb", 1'b0, 4'd0, 32'h0);

    // POP {r1,pc} with first transfer held for two cycles
    mem_ready = 1'b0;
    issue(16'hBD02, 32'h0000_3000);
    xfer_chk("pop_h0", 1'b0, 32'h0000_3000, 4'd1);
    xfer_chk("pop_h1", 1'b0, 32'h0000_3000, 4'd1);
    mem_ready = 1'b1;
    xfer_chk("pop_h2", 1'b0, 32'h0000_3000, 4'd1);
    xfer_chk("pop_pc", 1'b0, 32'h0000_3004, 4'd15);
    fin_chk("pop", 1'b1, 4'd13, 32'h0000_3008);

    // STM r2!,{r0-r4} aborted on the second transfer (mem_ready also high)
    issue(16'hC21F, 32'h0000_4000);
    xfer_chk("stm0", 1'b1, 32'h0000_4000, 4'd0);
    abort = 1'b1;
    check_eq("stm1.reg", 64'(xfer_reg), 64'd1);
    check_eq("stm1.addr", 64'(xfer_addr), 64'h4004);
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort.busy", 64'(busy), 64'd0);
    check_eq("abort.xvalid", 64'(xfer_valid), 64'd0);
    check_eq("abort.done", 64'(done), 64'd0);
    check_eq("abort.wbv", 64'(wb_valid), 64'd0);

    // Following cycle: empty-list STM is accepted, done on cycle 1, no wb
    issue(16'hC000, 32'h0000_5000);
    check_eq("empty.xvalid", 64'(xfer_valid), 64'd0);
    fin_chk("empty", 1'b0, 4'd0, 32'h0);

    // Ignored starts: 32-bit, non-class, and start together with abort
    is32 = 1'b1;
    issue(16'hB505, 32'h0000_6000);
    is32 = 1'b0;
    check_eq("is32.busy", 64'(busy), 64'd0);
    check_eq("is32.xvalid", 64'(xfer_valid), 64'd0);
    issue(16'h4608, 32'h0000_6000);
    check_eq("nonclass.busy", 64'(busy), 64'd0);
    check_eq("nonclass.xvalid", 64'(xfer_valid), 64'd0);
    abort = 1'b1;
    issue(16'hB505, 32'h0000_6000);
    abort = 1'b0;
    check_eq("startabort.busy", 64'(busy), 64'd0);

    // Start while busy must not disturb the running LDM
    mem_ready = 1'b0;
    issue(16'hC909, 32'h0000_1000);
    issue(16'hB505, 32'h2000_0100);
    mem_ready = 1'b1;
    xfer_chk("busy0", 1'b0, 32'h0000_1000, 4'd0);
    xfer_chk("busy1", 1'b0, 32'h0000_1004, 4'd3);
    fin_chk("busy", 1'b1, 4'd1, 32'h0000_1008);

    // Asynchronous reset mid-XFER
    mem_ready = 1'b0;
    issue(16'hC21F, 32'h0000_4000);
    check_eq("rst.busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero_chk("midrst");
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);

    // Address wrap: PUSH {r0} from base 0
    issue(16'hB401, 32'h0000_0000);
    xfer_chk("wrap0", 1'b1, 32'hFFFF_FFFC, 4'd0);
    fin_chk("wrap", 1'b1, 4'd13, 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_xfer_seq.md
Name: mm_xfer_seq

Overview:
Parametrised multi-cycle load/store-multiple sequencer for the Cortex-M0 core; successor to the combinational multiple-pulse detector.
- Decodes the 16-bit multiple-transfer instruction classes: LDM, STM, PUSH, POP.
- Walks the register list and issues one memory transfer per accepted cycle, with address, register index and direction.
- Holds fetch stalled while busy.
- Produces the base-register writeback value at completion.
- Sits between decode and the load/store unit.

Parameters:
- ADDR_W, 32, width of base address and transfer address.
- LIST_W, 8, number of low-register list bits taken from instr16[LIST_W-1:0]; legal range 1..8.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  decode-stage strobe: instruction valid this cycle.
- is32  in  1  instruction is a 32-bit encoding; blocks start when 1.
- instr16  in  16  16-bit instruction.
- base_addr  in  ADDR_W  value of Rn (LDM/STM) or SP (PUSH/POP), sampled with start.
- mem_ready  in  1  load/store unit accepts the current transfer.
- abort  in  1  fault or flush; kills the sequence.
- busy  out  1  sequence in progress.
- stall_fetch  out  1  equals busy.
- xfer_valid  out  1  transfer request.
- xfer_write  out  1  1 = store (STM/PUSH), 0 = load.
- xfer_addr  out  ADDR_W  word address of the transfer.
- xfer_reg  out  4  register number being transferred.
- wb_valid  out  1  one-cycle base writeback strobe.
- wb_reg  out  4  register to write back: Rn, or 13 for SP.
- wb_data  out  ADDR_W  writeback value.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; every output 0.
- Accept condition: start & ~is32 & ~busy & class match. Classes:
  - STM: instr16[15:11] = 11000.
  - LDM: instr16[15:11] = 11001.
  - PUSH: instr16[15:9] = 1011010.
  - POP: instr16[15:9] = 1011110.
- start under any other condition is ignored with no state change.
- Transfer list is instr16[LIST_W-1:0], plus an extra bit instr16[8] for PUSH/POP only: PUSH adds r14 (LR), POP adds r15 (PC).
- N = population count of the transfer list, 0..LIST_W+1; count register is clog2(LIST_W+2) bits.
- Start address and writeback, all ADDR_W-bit modulo 2^ADDR_W:
  - LDM/STM/POP: start address = base_addr; wb_data = base_addr + 4*N.
  - PUSH: start address = base_addr - 4*N; wb_data = same value.
- Writeback rules:
  - STM, PUSH, POP: always write back.
  - LDM: write back only if Rn (instr16[10:8]) is not in the list.
  - wb_reg = 13 for PUSH/POP, otherwise Rn.
- Transfer order: ascending register number at ascending addresses, +4 per transfer.
- FSM: IDLE -> XFER -> FIN -> IDLE.
  - IDLE: on accept, latch the list, address and direction, then go to XFER. If N = 0, go to FIN directly with no writeback.
  - XFER: xfer_valid = 1; xfer_reg is the lowest remaining list bit.
    - Outputs stay stable until mem_ready.
    - On mem_ready: clear that bit and advance the address by 4.
    - If it was the last bit, go to FIN.
  - FIN: done = 1 and wb_valid per the writeback rules for one cycle, then IDLE.
- busy = 1 in XFER and FIN.
- Latency: accept at cycle 0 gives the first xfer_valid at cycle 1. With mem_ready held high, done occurs at cycle N+1.
- Abort:
  - abort in any non-IDLE state goes to IDLE next cycle.
  - No done, no wb_valid; xfer_valid drops next cycle.
  - abort has priority over mem_ready in the same cycle; that transfer is treated as not accepted.
  - start in the same cycle as abort while IDLE is ignored.
- Reset mid-operation: immediate return to the reset state.
- start while busy: ignored; decode must hold the instruction.

Decomposition:
- Shared package mm_pkg:
  - class opcodes and masks;
  - REG_LR = 14, REG_PC = 15, REG_SP = 13;
  - state encoding IDLE/XFER/FIN.
- One sub-module: mm_prio_enc, a lowest-set-bit priority encoder over LIST_W+1 bits giving the index and a valid flag.
- Popcount is an inline function in mm_pkg.

Test Plan:
- PUSH {r0,r2,lr} (0xB505), base 0x20000100, mem_ready = 1 -> stores r0@0x200000F4, r2@0x200000F8, r14@0x200000FC on cycles 1-3; done on cycle 4; wb reg 13 = 0x200000F4.
- LDM r1!,{r0,r3} (0xC909), base 0x1000 -> loads r0@0x1000, r3@0x1004; wb reg 1 = 0x1008. Then LDM r0,{r0,r1} (0xC803) -> two loads, done, no wb_valid.
- POP {r1,pc} (0xBD02), base 0x3000, mem_ready low for 2 cycles on the first transfer -> r1@0x3000 held stable 3 cycles, then r15@0x3004; wb 0x3008.
- abort asserted during the 2nd transfer of STM r2!,{r0-r4} (0xC21F) -> IDLE next cycle; no done, no wb_valid; a new start is accepted the following cycle.
- start with is32 = 1, or instr16 = 0x4608, or while busy -> no busy, no xfer. rst_n low mid-XFER -> all outputs 0 asynchronously.
- Empty-list STM (0xC000) -> done on cycle 1, no xfer, no wb. Wrap: PUSH {r0} with base 0x00000000 -> xfer_addr 0xFFFFFFFC.
